// File: rtl/lepteto_vezerlo.sv
// 4-coil unipolar stepper sequencer: wave/full/half drive, counted moves, signed position.
// Define LEPTETO_HOLD_EN to keep the last coil pattern energised between moves.
module lepteto_vezerlo #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned STEP_W = 16,
    parameter int unsigned POS_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              dir,
    input  logic [DIV_W-1:0]  period,
    input  logic [STEP_W-1:0] steps,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic [3:0]        tekercsek,
    output logic [POS_W-1:0]  position
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        ph_q, ph_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [1:0]        mode_q, mode_d;
    logic              dir_q, dir_d;
    logic [DIV_W-1:0]  period_q, period_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        coil_q, coil_d;
`ifdef LEPTETO_HOLD_EN
    logic              energ_q, energ_d;
`endif

    logic [1:0]        step_sz;
    logic [2:0]        ph_step;
    logic [POS_W-1:0]  pos_step;

    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    return 4'b0001;
            3'd1:    return 4'b0011;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0100;
            3'd5:    return 4'b1100;
            3'd6:    return 4'b1000;
            default: return 4'b1001;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        pos_d    = pos_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        period_d = period_q;
        presc_d  = presc_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef LEPTETO_HOLD_EN
        energ_d  = energ_q;
`endif

        // Wave wants even ph, full wants odd ph (matches mode bit 0); a mismatch
        // takes a single half step, which also realigns the phase for later steps.
        step_sz  = (mode_q[1] || (ph_q[0] != mode_q[0])) ? 2'd1 : 2'd2;
        ph_step  = dir_q ? ph_q + {1'b0, step_sz} : ph_q - {1'b0, step_sz};
        pos_step = dir_q ? pos_q + POS_W'(step_sz) : pos_q - POS_W'(step_sz);

        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d   = mode;
                    dir_d    = dir;
                    period_d = (period == '0) ? DIV_W'(1) : period;
                    rem_d    = steps;
                    presc_d  = '0;
                    if (steps == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        busy_d  = 1'b1;
`ifdef LEPTETO_HOLD_EN
                        energ_d = 1'b1;
`endif
                    end
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (presc_q == period_q - DIV_W'(1)) begin
                    presc_d = '0;
                    ph_d    = ph_step;
                    pos_d   = pos_step;
                    rem_d   = rem_q - STEP_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StRun) begin
            coil_d = phase_pattern(ph_d);
`ifdef LEPTETO_HOLD_EN
        end else if (energ_d) begin
            coil_d = phase_pattern(ph_d);
`endif
        end else begin
            coil_d = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ph_q     <= '0;
            pos_q    <= '0;
            mode_q   <= '0;
            dir_q    <= 1'b0;
            period_q <= '0;
            presc_q  <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            coil_q   <= 4'b0000;
`ifdef LEPTETO_HOLD_EN
            energ_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            pos_q    <= pos_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            presc_q  <= presc_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            coil_q   <= coil_d;
`ifdef LEPTETO_HOLD_EN
            energ_q  <= energ_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign tekercsek = coil_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_lepteto_vezerlo.sv
// Self-checking bench for lepteto_vezerlo: directed vector table, hand sequences and
// randomized moves checked cycle by cycle against a step-list model of each move.
module tb_lepteto_vezerlo;

    localparam int DIV_W  = 16;
    localparam int STEP_W = 16;
    localparam int POS_W  = 24;
    localparam logic [3:0] PHASE [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                         4'b0100, 4'b1100, 4'b1000, 4'b1001};

    logic              clk;
    logic              rst;
    logic [1:0]        mode;
    logic              dir;
    logic [DIV_W-1:0]  period;
    logic [STEP_W-1:0] steps;
    logic              start;
    logic              stop;
    logic              busy;
    logic              done;
    logic [3:0]        tekercsek;
    logic [POS_W-1:0]  position;

    lepteto_vezerlo #(
        .DIV_W (DIV_W),
        .STEP_W(STEP_W),
        .POS_W (POS_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .dir      (dir),
        .period   (period),
        .steps    (steps),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .tekercsek(tekercsek),
        .position (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state carried between moves.
    int m_ph    = 0;
    int m_pos   = 0;
    bit m_energ = 1'b0;

    typedef struct {
        logic [1:0] mode;
        logic       dir;
        int         period;
        int         steps;
        int         stop_at;
        bit         glitch;
        int         exp_pos;
        int         exp_done;
        logic [3:0] exp_last;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pos_bits(input int v);
        return v & ((1 << POS_W) - 1);
    endfunction

    function automatic logic [3:0] idle_coil(input int ph);
        bit keep;
`ifdef LEPTETO_HOLD_EN
        keep = m_energ;
`else
        keep = 1'b0;
`endif
        return keep ? PHASE[ph] : 4'b0000;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        m_ph    = 0;
        m_pos   = 0;
        m_energ = 1'b0;
    endtask

    // Runs one move and checks every cycle from acceptance to idle against the step list.
    task automatic run_move(input logic [1:0] md, input logic dr, input int per, input int n,
                            input int stop_at, input bit glitch, input bit idle_stop,
                            output int seen_done, output logic [3:0] last_coil);
        int p, end_c, kf, k, d, tgt;
        bit half;
        int ph_arr[$];
        int pos_arr[$];
        p    = (per == 0) ? 1 : per;
        half = md[1];
        tgt  = (md == 2'd1) ? 1 : 0;
        ph_arr.push_back(m_ph);
        pos_arr.push_back(m_pos);
        for (int i = 1; i <= n; i++) begin
            if (half) d = 1;
            else if (i == 1 && (ph_arr[i-1] % 2) != tgt) d = 1;
            else d = 2;
            if (!dr) d = -d;
            ph_arr.push_back((ph_arr[i-1] + d + 8) % 8);
            pos_arr.push_back(pos_arr[i-1] + d);
        end
        end_c = (n == 0) ? 0 : ((stop_at > 0) ? stop_at : n * p);
        kf    = (n == 0) ? 0 : ((stop_at > 0) ? (stop_at - 1) / p : n);
        if (n > 0) m_energ = 1'b1;

        @(negedge clk);
        mode   = md;
        dir    = dr;
        period = per[DIV_W-1:0];
        steps  = n[STEP_W-1:0];
        start  = 1'b1;
        stop   = idle_stop;
        @(negedge clk);
        start     = 1'b0;
        seen_done = 0;
        last_coil = 4'b0000;
        for (int c = 1; c <= end_c + 2; c++) begin
            if (done === 1'b1 && seen_done == 0) seen_done = c;
            if (c <= end_c) begin
                k = (c - 1) / p;
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_done", 32'(done), 32'd0);
                chk("run_coil", 32'(tekercsek), 32'(PHASE[ph_arr[k]]));
                chk("run_pos", 32'(position), pos_bits(pos_arr[k]));
                last_coil = tekercsek;
            end else begin
                chk(c == end_c + 1 ? "end_busy" : "idle_busy", 32'(busy), 32'd0);
                chk(c == end_c + 1 ? "end_done" : "idle_done", 32'(done),
                    (c == end_c + 1) ? 32'd1 : 32'd0);
                chk("end_coil", 32'(tekercsek), 32'(idle_coil(ph_arr[kf])));
                chk("end_pos", 32'(position), pos_bits(pos_arr[kf]));
            end
            stop  = (stop_at > 0 && c == stop_at);
            start = glitch && ((c == 2 && end_c >= 2) || c == end_c + 1);
            @(negedge clk);
        end
        stop  = 1'b0;
        start = 1'b0;
        m_ph  = ph_arr[kf];
        m_pos = pos_arr[kf];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         sd, p, n, per, sa;
        logic [3:0] lc;

        vecs[0] = '{2'd2, 1'b1, 4, 8, 0, 1'b0, 8, 33, 4'b1001};
        vecs[1] = '{2'd1, 1'b0, 2, 3, 0, 1'b0, -5, 7, 4'b1100};
        vecs[2] = '{2'd0, 1'b1, 0, 5, 0, 1'b0, 10, 6, 4'b0001};
        vecs[3] = '{2'd2, 1'b1, 3, 0, 0, 1'b1, 0, 1, 4'b0000};
        vecs[4] = '{2'd2, 1'b1, 10, 100, 35, 1'b1, 3, 36, 4'b0110};
        vecs[5] = '{2'd3, 1'b0, 1, 3, 0, 1'b0, -3, 4, 4'b1000};
        vecs[6] = '{2'd2, 1'b1, 4, 5, 8, 1'b0, 1, 9, 4'b0011};

        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 2'd0;
        dir    = 1'b0;
        period = '0;
        steps  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_coil", 32'(tekercsek), 32'd0);
        chk("reset_pos", 32'(position), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_reset();
            run_move(vecs[i].mode, vecs[i].dir, vecs[i].period, vecs[i].steps,
                     vecs[i].stop_at, vecs[i].glitch, vecs[i].glitch, sd, lc);
            chk("vec_done_cycle", 32'(sd), 32'(vecs[i].exp_done));
            chk("vec_final_pos", 32'(position), pos_bits(vecs[i].exp_pos));
            chk("vec_last_run_coil", 32'(lc), 32'(vecs[i].exp_last));
        end

        // start held high: ignored in DONE, accepted again two cycles after the last step
        do_reset();
        @(negedge clk);
        mode = 2'd2; dir = 1'b1; period = 16'd1; steps = 16'd1; start = 1'b1;
        @(negedge clk);
        chk("b2b_busy1", 32'(busy), 32'd1);
        chk("b2b_coil1", 32'(tekercsek), 32'(PHASE[0]));
        @(negedge clk);
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_pos1", 32'(position), 32'd1);
        @(negedge clk);
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        chk("b2b_gap_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy2", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_pos2", 32'(position), 32'd2);
        m_ph = 2; m_pos = 2; m_energ = 1'b1;
        @(negedge clk);
        chk("b2b_idle_coil", 32'(tekercsek), 32'(idle_coil(2)));

        // stop outside RUN does nothing
        stop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stop = 1'b0;
        chk("idle_stop_done", 32'(done), 32'd0);
        chk("idle_stop_pos", 32'(position), 32'd2);

        // reset mid-move: immediate abandon, no done pulse
        @(negedge clk);
        mode = 2'd2; dir = 1'b1; period = 16'd3; steps = 16'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_coil", 32'(tekercsek), 32'd0);
        chk("mid_rst_pos", 32'(position), 32'd0);
        m_ph = 0; m_pos = 0; m_energ = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_done", 32'(done), 32'd0);
        end

        // zero-length after reset keeps coils off even with holding enabled
        run_move(2'd1, 1'b1, 2, 0, 0, 1'b0, 1'b0, sd, lc);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            per = $urandom_range(0, 5);
            n   = $urandom_range(0, 7);
            p   = (per == 0) ? 1 : per;
            sa  = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, n * p) : 0;
            run_move(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), per, n, sa,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sd, lc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lepteto_vezerlo.md
# lepteto_vezerlo

Parametrised 4-coil unipolar stepper sequencer that supersedes the fixed single-mode drivers. It provides run-time selectable wave, full (two-phase) and half-step drive, direction control and a programmable step period. It also executes counted moves with a start/done handshake and keeps a signed position count. It sits between the motion-command logic and the coil driver pins.

## Interface
- `DIV_W`, 16: width of step-period input (clock cycles per step).
- `STEP_W`, 16: width of move-length input.
- `POS_W`, 24: width of signed position counter (half-step units).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode` in 2: 00 wave, 01 full, 10 half, 11 treated as half; latched at start.
- `dir` in 1: 1 forward (phase index increments), 0 reverse; latched at start.
- `period` in DIV_W: cycles per step; latched at start; 0 treated as 1.
- `steps` in STEP_W: number of steps for the move; latched at start.
- `start` in 1: move request, sampled only in IDLE.
- `stop` in 1: abort the running move.
- `busy` out 1: high while a move runs.
- `done` out 1: single-cycle pulse at move end (normal, zero-length or aborted).
- `tekercsek` out 4: coil drive, bit 0 = coil A .. bit 3 = coil D.
- `position` out POS_W: signed position, two's complement.

## Operation
- Phase table indexed by 3-bit `ph`, 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- Wave uses even `ph`, full uses odd `ph`, half uses all.
- Step size is ±2 in wave/full and ±1 in half. `ph` wraps mod 8.
- Parity alignment: if at start the `ph` parity does not match the latched mode, the first step of the move is ±1, and later steps are ±2. It still counts as one step.
- `position` changes by the actual `ph` delta (±1 or ±2) on every step and wraps silently.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: on `start`=1, latch `mode`, `dir`, `period` and `steps`. If `steps`=0, go to DONE with no coil change. Otherwise go to RUN and clear the prescaler.
  - RUN: the prescaler counts 0..period-1. At terminal count, perform one step and decrement the remaining count. After the last step, go to DONE.
  - RUN with `stop`=1: go to DONE on the next edge. No step is taken in that cycle, even at terminal count; `stop` has priority.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored in RUN and DONE. `stop` is ignored outside RUN.
- `tekercsek` in RUN is table[`ph`]. In IDLE/DONE it follows the hold configuration.
- Reset values: FSM IDLE, `ph`=0, `position`=0, `busy`=0, `done`=0, `tekercsek`=0000, energised flag cleared.
- Reset mid-move: the move is abandoned immediately, with no `done` pulse.

## Timing
- `start` accepted at edge T0: `busy`=1 and `tekercsek`=table[`ph`] from T0+1.
- Step k (k=1..N) updates `ph` and `position` at edge T0+k·P, where P = max(`period`,1).
- Last step at T0+N·P; `done`=1 and `busy`=0 from T0+N·P+1 for one cycle.
- The earliest next accepted `start` is at T0+N·P+2.
- Zero-length move: `done`=1 at T0+1; `busy` never rises.
- `stop` sampled at edge S: `done`=1 from S+1; `ph` and `position` hold their last stepped values.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `LEPTETO_HOLD_EN` defined: once any move has started after reset, `tekercsek` = table[`ph`] in IDLE and DONE as well, so holding torque is kept. Only `rst` de-energises the coils.
- `LEPTETO_HOLD_EN` undefined: `tekercsek`=0000 in IDLE and DONE; coils are energised only in RUN.

## Test plan
- Reset, then half mode, dir=1, period=4, steps=8 -> `tekercsek` sequence 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001, 0001. Changes every 4 cycles, `position`=8, `done` pulse at T0+33.
- From `ph`=0, full mode, dir=0, period=2, steps=3 -> alignment step to `ph`=7 (1001), then 5 (1100), then 3 (0110). `position`=-5.
- Wave mode, dir=1, steps=5, `period`=0 -> one step per cycle: 0001→0010→0100→1000→0001→0010. `position` +10, `done` at T0+6.
- `steps`=0 with `start` -> `done` at T0+1, `busy` stays 0, `ph` and `position` unchanged.
- Half mode, period=10, steps=100, `stop` asserted at T0+35 -> exactly 3 steps, `done` at T0+36, `position`=3, and a `start` during RUN is ignored.
- After the move ends: with `LEPTETO_HOLD_EN`, coils hold the last pattern until `rst`; without it, coils read 0000. `rst` asserted mid-RUN -> all outputs at reset values next cycle.
